// File: rtl/mul10_arb_pkg.sv
// rtl/mul10_arb_pkg.sv - shared constants and owner-tag type for the two-requester multiplier arbiter
package mul10_arb_pkg;

  // Operand width and exact (untruncated) product width
  localparam int W   = 10;
  localparam int PW  = 2 * W;

  // Edges from acceptance to the registered response
  localparam int LAT = 3;

  // Identifies which requester an in-flight operation belongs to; also
  // used as the round-robin pointer state
  typedef enum logic {
    OWNER_0 = 1'b0,
    OWNER_1 = 1'b1
  } owner_t;

  // The requester that is not o
  function automatic owner_t other_owner(input owner_t o);
    return (o == OWNER_0) ? OWNER_1 : OWNER_0;
  endfunction

endpackage

// File: rtl/mul10_arbiter_if.sv
// rtl/mul10_arbiter_if.sv - request/response bundle between two requesters and the shared multiplier
interface mul10_arbiter_if #(
  parameter int W  = mul10_arb_pkg::W,
  parameter int PW = mul10_arb_pkg::PW
);

  logic          req0_valid;
  logic [W-1:0]  req0_a;
  logic [W-1:0]  req0_b;
  logic          req0_ready;

  logic          req1_valid;
  logic [W-1:0]  req1_a;
  logic [W-1:0]  req1_b;
  logic          req1_ready;

  logic          rsp0_valid;
  logic [PW-1:0] rsp0_p;
  logic          rsp1_valid;
  logic [PW-1:0] rsp1_p;

  logic          busy;

  // Requester side
  modport master (
    output req0_valid, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    input  req1_ready,
    input  rsp0_valid, rsp0_p,
    input  rsp1_valid, rsp1_p,
    input  busy
  );

  // Arbiter side
  modport slave (
    input  req0_valid, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    output req1_ready,
    output rsp0_valid, rsp0_p,
    output rsp1_valid, rsp1_p,
    output busy
  );

endinterface

// File: rtl/mul10_pipe.sv
// rtl/mul10_pipe.sv - unsigned W x W multiplier with registered operands and registered product
module mul10_pipe #(
  parameter int W  = mul10_arb_pkg::W,
  parameter int PW = mul10_arb_pkg::PW
) (
  input  logic          clk,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic [PW-1:0] p
);

  logic [W-1:0] a_q;
  logic [W-1:0] b_q;

  // Operand capture: first edge of the two-edge latency
  always_ff @(posedge clk) begin
    a_q <= a;
    b_q <= b;
  end

  // Full-width product register: second edge; widening before the multiply keeps every bit
  always_ff @(posedge clk) begin
    p <= PW'(a_q) * PW'(b_q);
  end

endmodule

// File: rtl/mul10_arbiter.sv
// rtl/mul10_arbiter.sv - round-robin arbiter sharing one pipelined multiplier between two requesters
module mul10_arbiter #(
  parameter int W  = mul10_arb_pkg::W,
  parameter int PW = mul10_arb_pkg::PW
) (
  input logic           clk,
  input logic           rst,
  mul10_arbiter_if.slave bus
);

  import mul10_arb_pkg::*;

  // Round-robin pointer: names the requester that wins the next contended cycle
  owner_t        ptr_q;
  owner_t        ptr_d;

  logic          contended;
  logic          grant0;
  logic          grant1;
  logic          accept;
  owner_t        acc_owner;

  logic [W-1:0]  mul_a;
  logic [W-1:0]  mul_b;
  logic [PW-1:0] mul_p;
  logic [PW-1:0] prod_q;

  // Valid/owner shift pipeline; index 0 is loaded at the accepting edge
  logic [LAT-1:0] vld_q;
  owner_t         tag_q [LAT];

  logic          rsp0_valid_q;
  logic          rsp1_valid_q;
  logic [PW-1:0] rsp0_p_q;
  logic [PW-1:0] rsp1_p_q;

  logic          out_valid;
  owner_t        out_owner;

  // Grant decision and pointer next state; the pointer only moves when both requesters compete
  always_comb begin
    ptr_d     = ptr_q;
    grant0    = 1'b0;
    grant1    = 1'b0;
    contended = bus.req0_valid && bus.req1_valid;
    if (!rst) begin
      if (contended) begin
        grant0 = (ptr_q == OWNER_0);
        grant1 = (ptr_q == OWNER_1);
        ptr_d  = other_owner(ptr_q);
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  // Pointer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= OWNER_0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  assign accept    = grant0 || grant1;
  assign acc_owner = grant1 ? OWNER_1 : OWNER_0;

  // Operand mux into the shared multiplier; values when nothing is accepted are never observed
  always_comb begin
    mul_a = bus.req0_a;
    mul_b = bus.req0_b;
    if (grant1) begin
      mul_a = bus.req1_a;
      mul_b = bus.req1_b;
    end
  end

  mul10_pipe #(
    .W  (W),
    .PW (PW)
  ) u_mul (
    .clk (clk),
    .a   (mul_a),
    .b   (mul_b),
    .p   (mul_p)
  );

  // Valid bits shift every cycle; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= {vld_q[LAT-2:0], accept};
    end
  end

  // Owner tags follow their valid bits; they only matter where the valid bit is set
  always_ff @(posedge clk) begin
    tag_q[0] <= acc_owner;
    for (int i = 1; i < LAT; i++) begin
      tag_q[i] <= tag_q[i-1];
    end
  end

  // Product leaves the multiplier one edge before the last tag stage; align it with that stage
  always_ff @(posedge clk) begin
    prod_q <= mul_p;
  end

  assign out_valid = vld_q[LAT-1];
  assign out_owner = tag_q[LAT-1];

  // Response registers: one-cycle pulse to the owner, product held between pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_p_q     <= '0;
      rsp1_p_q     <= '0;
    end else begin
      rsp0_valid_q <= out_valid && (out_owner == OWNER_0);
      rsp1_valid_q <= out_valid && (out_owner == OWNER_1);
      if (out_valid && (out_owner == OWNER_0)) begin
        rsp0_p_q <= prod_q;
      end
      if (out_valid && (out_owner == OWNER_1)) begin
        rsp1_p_q <= prod_q;
      end
    end
  end

  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp0_p     = rsp0_p_q;
  assign bus.rsp1_p     = rsp1_p_q;
  assign bus.busy       = |vld_q;

endmodule

// File: tb/tb_mul10_arbiter.sv
// tb/tb_mul10_arbiter.sv - directed table-driven bench for mul10_arbiter
module tb_mul10_arbiter;

  logic clk;
  logic rst;

  int checks;
  int errors;

  mul10_arbiter_if #(.W(10), .PW(20)) bus ();

  mul10_arbiter #(.W(10), .PW(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic [9:0]  a0;
    logic [9:0]  b0;
    logic        v1;
    logic [9:0]  a1;
    logic [9:0]  b1;
    logic        r0;
    logic        r1;
    logic        o0;
    logic [19:0] p0;
    logic        o1;
    logic [19:0] p1;
    logic        busy;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t mk(input int v0, input int a0, input int b0,
                              input int v1, input int a1, input int b1,
                              input int r0, input int r1,
                              input int o0, input int p0,
                              input int o1, input int p1, input int busy);
    vec_t v;
    v.v0 = v0[0]; v.a0 = a0[9:0]; v.b0 = b0[9:0];
    v.v1 = v1[0]; v.a1 = a1[9:0]; v.b1 = b1[9:0];
    v.r0 = r0[0]; v.r1 = r1[0];
    v.o0 = o0[0]; v.p0 = p0[19:0];
    v.o1 = o1[0]; v.p1 = p1[19:0];
    v.busy = busy[0];
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int v0, input int a0, input int b0,
                       input int v1, input int a1, input int b1);
    bus.req0_valid = v0[0];
    bus.req0_a     = a0[9:0];
    bus.req0_b     = b0[9:0];
    bus.req1_valid = v1[0];
    bus.req1_a     = a1[9:0];
    bus.req1_b     = b1[9:0];
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_ready(input string tag, input int r0, input int r1);
    check({tag, " req0_ready"}, int'(bus.req0_ready), r0);
    check({tag, " req1_ready"}, int'(bus.req1_ready), r1);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Row i is driven before edge Ei; its outputs are those seen after Ei.
    vecs[0]  = mk(0, 0, 0,    0, 0, 0,       0, 0,  0, 0,   0, 0,       0);
    vecs[1]  = mk(1, 3, 5,    0, 0, 0,       1, 0,  0, 0,   0, 0,       1);
    vecs[2]  = mk(0, 0, 0,    0, 0, 0,       0, 0,  0, 0,   0, 0,       1);
    vecs[3]  = mk(0, 0, 0,    0, 0, 0,       0, 0,  0, 0,   0, 0,       1);
    vecs[4]  = mk(0, 0, 0,    0, 0, 0,       0, 0,  1, 15,  0, 0,       0);
    vecs[5]  = mk(1, 2, 3,    1, 4, 5,       1, 0,  0, 15,  0, 0,       1);
    vecs[6]  = mk(1, 6, 7,    1, 4, 5,       0, 1,  0, 15,  0, 0,       1);
    vecs[7]  = mk(1, 6, 7,    1, 8, 9,       1, 0,  0, 15,  0, 0,       1);
    vecs[8]  = mk(1, 10, 11,  1, 8, 9,       0, 1,  1, 6,   0, 0,       1);
    vecs[9]  = mk(0, 0, 0,    1, 1023, 1023, 0, 1,  0, 6,   1, 20,      1);
    vecs[10] = mk(1, 0, 1023, 0, 0, 0,       1, 0,  1, 42,  0, 20,      1);
    vecs[11] = mk(0, 0, 0,    0, 0, 0,       0, 0,  0, 42,  1, 72,      1);
    vecs[12] = mk(0, 0, 0,    0, 0, 0,       0, 0,  0, 42,  1, 1046529, 1);
    vecs[13] = mk(0, 0, 0,    0, 0, 0,       0, 0,  1, 0,   0, 1046529, 0);
    vecs[14] = mk(0, 0, 0,    0, 0, 0,       0, 0,  0, 0,   0, 1046529, 0);
    vecs[15] = mk(1, 1, 1,    1, 2, 2,       1, 0,  0, 0,   0, 1046529, 1);
    vecs[16] = mk(1, 3, 3,    1, 2, 2,       0, 1,  0, 0,   0, 1046529, 1);
    vecs[17] = mk(0, 0, 0,    0, 0, 0,       0, 0,  0, 0,   0, 1046529, 1);
    vecs[18] = mk(0, 0, 0,    0, 0, 0,       0, 0,  1, 1,   0, 1046529, 1);
    vecs[19] = mk(0, 0, 0,    0, 0, 0,       0, 0,  0, 1,   1, 4,       0);
    vecs[20] = mk(0, 0, 0,    0, 0, 0,       0, 0,  0, 1,   0, 4,       0);

    // Reset: ready held low even with both requesters valid
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 1, 1, 1, 1);
    check_ready("reset", 0, 0);
    tick();
    check("reset busy", int'(bus.busy), 0);
    check("reset rsp0_valid", int'(bus.rsp0_valid), 0);
    check("reset rsp1_valid", int'(bus.rsp1_valid), 0);
    check("reset rsp0_p", int'(bus.rsp0_p), 0);
    check("reset rsp1_p", int'(bus.rsp1_p), 0);
    rst = 1'b0;

    // Table: single op, contention, max operands, zero operand, pointer behaviour
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].v0, vecs[i].a0, vecs[i].b0, vecs[i].v1, vecs[i].a1, vecs[i].b1);
      check_ready($sformatf("v%0d", i), vecs[i].r0, vecs[i].r1);
      tick();
      check($sformatf("v%0d rsp0_valid", i), int'(bus.rsp0_valid), int'(vecs[i].o0));
      check($sformatf("v%0d rsp0_p", i),     int'(bus.rsp0_p),     int'(vecs[i].p0));
      check($sformatf("v%0d rsp1_valid", i), int'(bus.rsp1_valid), int'(vecs[i].o1));
      check($sformatf("v%0d rsp1_p", i),     int'(bus.rsp1_p),     int'(vecs[i].p1));
      check($sformatf("v%0d busy", i),       int'(bus.busy),       int'(vecs[i].busy));
    end

    // Streaming: a=10, b=0..7 back-to-back, products appear on 8 consecutive cycles
    for (int c = 0; c < 11; c++) begin
      if (c < 8) drive(1, 10, c, 0, 0, 0);
      else       drive(0, 0, 0, 0, 0, 0);
      check_ready($sformatf("stream%0d", c), (c < 8) ? 1 : 0, 0);
      tick();
      check($sformatf("stream%0d rsp0_valid", c), int'(bus.rsp0_valid), (c >= 3) ? 1 : 0);
      if (c >= 3)
        check($sformatf("stream%0d rsp0_p", c), int'(bus.rsp0_p), (c - 3) * 10);
      check($sformatf("stream%0d rsp1_valid", c), int'(bus.rsp1_valid), 0);
      check($sformatf("stream%0d busy", c), int'(bus.busy), (c <= 9) ? 1 : 0);
    end

    // Reset mid-flight: contended grant moves pointer to 1, then reset the next cycle
    drive(1, 5, 5, 1, 6, 6);
    check_ready("mid accept", 1, 0);
    tick();
    rst = 1'b1;
    drive(1, 5, 5, 1, 6, 6);
    check_ready("mid in_reset", 0, 0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    check("mid busy", int'(bus.busy), 0);
    check("mid rsp0_p", int'(bus.rsp0_p), 0);
    check("mid rsp1_p", int'(bus.rsp1_p), 0);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("mid%0d rsp0_valid", c), int'(bus.rsp0_valid), 0);
      check($sformatf("mid%0d rsp1_valid", c), int'(bus.rsp1_valid), 0);
      check($sformatf("mid%0d busy", c), int'(bus.busy), 0);
      tick();
    end
    drive(1, 2, 2, 1, 3, 3);
    check_ready("mid pointer", 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul10_arbiter.md
MUL10_ARBITER -- requirements
Module: mul10_arbiter

Interface
REQ-001 Parameter W, default 10: operand width in bits.
REQ-002 Parameter PW, default 20: product width in bits, fixed at 2*W.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req0_valid  input  1  requester 0 has an operand pair.
REQ-006 req0_a, req0_b  input  W each  requester 0 unsigned operands.
REQ-007 req0_ready  output  1  requester 0 pair accepted this cycle.
REQ-008 req1_valid, req1_a, req1_b, req1_ready  same as REQ-005 to REQ-007, for requester 1.
REQ-009 rsp0_valid  output  1  one-cycle pulse: product for requester 0.
REQ-010 rsp0_p  output  PW  requester 0 product.
REQ-011 rsp1_valid, rsp1_p  same as REQ-009 and REQ-010, for requester 1.
REQ-012 busy  output  1  high while any accepted operation is still in flight.

Function
REQ-013 Acceptance: reqN_valid and reqN_ready both high at a rising edge; at most one acceptance per edge.
REQ-014 reqN_ready is combinational; it is high only when reqN_valid is high and N holds the grant.
REQ-015 Only one requester valid: that requester gets the grant.
REQ-016 Both requesters valid: the grant goes to the requester named by the round-robin pointer.
REQ-017 After a contended grant to N, the pointer moves to the other requester; an uncontended grant leaves the pointer unchanged.
REQ-018 Shared datapath: one W x W unsigned multiplier stage with registered operands and registered product, 2-edge latency.
REQ-019 A 1-bit owner tag travels with each operation through a 3-stage valid/tag shift pipeline.
REQ-020 Pair accepted at edge E: rspN_valid and rspN_p are registered outputs asserted after edge E+3, for exactly one cycle.
REQ-021 rspN_valid is never asserted for a cycle in which no accepted op reaches the output.
REQ-022 Throughput is one op per cycle, back-to-back, with no bubbles.
REQ-023 Results are returned in acceptance order; rsp0_valid and rsp1_valid are never high in the same cycle.
REQ-024 rspN_p is the exact unsigned product with no truncation; 1023 x 1023 = 1046529.
REQ-025 rspN_p holds its last value when rspN_valid is low.
REQ-026 The response path has no backpressure; requesters must accept every rspN_valid pulse.
REQ-027 busy equals the OR of the three tag-pipeline valid bits.
REQ-028 Requester inputs may change while reqN_ready is low without any effect on state.

Reset
REQ-029 While rst is high: req0_ready = req1_ready = 0; no acceptance.
REQ-030 After rst: rsp0_valid = rsp1_valid = 0, rsp0_p = rsp1_p = 0, busy = 0, pointer = requester 0.
REQ-031 Operations in flight when rst asserts are discarded and produce no response.

Structure
REQ-032 Package mul10_arb_pkg holds W, PW, the pipeline depth constant LAT = 3, and the owner-tag type.
REQ-033 The multiplier is one sub-module, mul10_pipe (inputs a, b; output p; 2-edge latency); arbitration, tag pipeline and response registers stay in mul10_arbiter.

Verification
REQ-034 Single op: req0 only, a=3, b=5, accepted at edge E -> rsp0_valid pulse after E+3, rsp0_p = 15; rsp1_valid stays 0.
REQ-035 Contention: both valid for 4 cycles, pointer at 0 -> grants 0,1,0,1; responses in the same order with the correct products.
REQ-036 Maximum operands: req1 a=1023, b=1023 -> rsp1_p = 1046529.
REQ-037 Streaming: req0 held valid 8 cycles, b=0..7, a=10 -> 8 consecutive rsp0_valid cycles, products 0,10,...,70; busy high throughout.
REQ-038 Reset mid-flight: rst asserted one cycle after an acceptance -> no rsp pulse; busy = 0 and pointer = 0 after reset.
REQ-039 Zero operand: req0 a=0, b=1023 -> rsp0_p = 0.
